mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port instruction/data memory between two requesters of the chip: instruction fetch (IF) and data load/store (D).
- Sits between chip and memory, driving the memory's write enable, address and write-data inputs and returning read data to the requester that issued the read.
- Provides valid/grant handshakes, configurable memory read latency, and round-robin or fixed-priority arbitration.

Parameters:
ADDR_W, 32, address width, passed through unchanged
DATA_W, 32, data width
MEM_LAT, 1, memory read latency in cycles (≥1); read data is valid MEM_LAT cycles after the address edge
D_PRIO, 0, 0 = round-robin on tie; 1 = D always wins tie

Ports:
clk_i  in  1  clock, rising edge
res_ni  in  1  reset, asynchronous, active-low
if_req_i  in  1  IF read request; held until granted
if_addr_i  in  ADDR_W  IF address
if_gnt_o  out  1  IF request accepted this cycle
if_rvalid_o  out  1  IF read data valid, one-cycle pulse
if_rdata_o  out  DATA_W  IF read data
d_req_i  in  1  D request; held until granted
d_we_i  in  1  D write (1) / read (0)
d_addr_i  in  ADDR_W  D address
d_wdata_i  in  DATA_W  D write data
d_gnt_o  out  1  D request accepted this cycle
d_rvalid_o  out  1  D read data valid, one-cycle pulse (reads only)
d_rdata_o  out  DATA_W  D read data
mem_wen_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data

Behaviour:
Reset:
- While res_ni is low, all outputs are 0 and the state is IDLE.
- last_q resets to IF, so the first tie goes to D under round-robin.

FSM states:
- IDLE: grants are possible.
- WAIT_IF: a read for IF is outstanding.
- WAIT_D: a read for D is outstanding.

Granting:
- Grants are combinational and occur only in IDLE.
- At most one gnt per cycle. The granted requester's address, we and wdata drive the mem_* outputs in the same cycle T.
- With no grant, mem_addr_o, mem_wdata_o and mem_wen_o are 0.

Arbitration:
- Only one requester: it is granted.
- Both requesting with D_PRIO=1: D is granted.
- Both requesting with D_PRIO=0: the requester not in last_q is granted. last_q updates on every grant.

Write (D only):
- mem_wen_o=1 in cycle T; the memory writes at the end of T.
- The FSM stays in IDLE, so a new grant is possible at T+1.
- No rvalid is produced.

Read:
- At T the FSM moves to WAIT_x and loads lat_cnt=MEM_LAT.
- lat_cnt decrements each cycle. In the cycle lat_cnt==1, mem_rdata_i is registered into x_rdata_o and the FSM returns to IDLE.
- x_rvalid_o is high for exactly cycle T+MEM_LAT+1.
- A new grant is allowed in that same cycle (overlap with rvalid is legal).
- Read throughput is 1 per MEM_LAT+1 cycles.

Other rules:
- Read data holding: x_rdata_o holds its last value until the next read for that port.
- Requests during WAIT_*: not granted. Requesters must hold req and addr stable until gnt; the arbiter never drops a held request.
- Reset mid-read: the state is cleared, the pending read is lost and no rvalid is issued. The requester reissues.
- Fairness: under round-robin with both requesting continuously, grants strictly alternate.
- lat_cnt width is $clog2(MEM_LAT+1).

Decomposition:
- Package mem_arb_pkg: state enum {IDLE, WAIT_IF, WAIT_D}, source enum {SRC_IF, SRC_D}, priority constants PRIO_RR=0 and PRIO_D=1.
- Sub-module rr_arb2: combinational 2-way arbiter taking req[1:0], last_q and D_PRIO, producing a one-hot grant. It is instantiated once in mem_arbiter.

Test Plan:
1. Reset: hold res_ni=0 with both requests active -> all outputs 0. Release -> D is granted first (round-robin tie).
2. IF read, MEM_LAT=1: if_addr=0x10 at T, memory returns 0xDEADBEEF -> if_gnt_o=1 at T, mem_addr_o=0x10, if_rvalid_o=1 at T+2 with if_rdata_o=0xDEADBEEF, no further grant at T+1.
3. D write then read: write 0xCAFEF00D to 0x20 at T, then read 0x20 -> mem_wen_o=1 at T, read granted at T+1, d_rvalid_o at T+3 with 0xCAFEF00D, no d_rvalid_o for the write.
4. Contention, D_PRIO=0: both requesting reads continuously -> grants alternate D, IF, D, IF every 2 cycles. With D_PRIO=1, only D is granted while d_req_i is held.
5. MEM_LAT=3: IF read at T -> if_rvalid_o exactly at T+4, no grant in T+1..T+3.
6. Reset mid-read: assert res_ni=0 at T+1 after an IF read grant -> no if_rvalid_o follows. After release, a reissued read completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/D memory arbiter: FSM states, request sources and
// arbitration-mode constants.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWaitIf = 2'd1,
    StWaitD  = 2'd2
  } state_e;

  typedef enum logic {
    SrcIf = 1'b0,
    SrcD  = 1'b1
  } src_e;

  localparam int unsigned PrioRr = 0;
  localparam int unsigned PrioD  = 1;

  // Bit positions of each requester in the req/gnt vectors.
  localparam int unsigned GntIf = 0;
  localparam int unsigned GntD  = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the IF and D requester handshakes plus the memory-side bus.
// The arbiter uses the slave view; whoever models the requesters and the memory uses master.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way arbiter (IF vs D): round-robin on a tie, or D-always-wins
// when D_PRIO selects fixed priority.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter int unsigned D_PRIO = PrioRr
) (
  input  logic [1:0] req_i,
  input  src_e       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01: gnt_o = 2'b01;
      2'b10: gnt_o = 2'b10;
      2'b11: begin
        // On a tie, D wins under fixed priority or when IF was served last.
        if (D_PRIO == PrioD || last_i == SrcIf) gnt_o = 2'b10;
        else                                    gnt_o = 2'b01;
      end
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Grants are combinational in idle; reads block further grants until the data returns.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned D_PRIO  = PrioRr
) (
  input  logic         clk_i,
  input  logic         res_ni,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);

  state_e            state_q, state_d;
  src_e              last_q, last_d;
  logic [CntW-1:0]   lat_cnt_q, lat_cnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic [1:0]        req, gnt_raw, gnt;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign req[GntIf] = bus.if_req;
  assign req[GntD]  = bus.d_req;

  rr_arb2 #(
    .D_PRIO (D_PRIO)
  ) u_rr_arb2 (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (gnt_raw)
  );

  // Gating with res_ni keeps every output low while reset is held.
  assign gnt = (state_q == StIdle && res_ni) ? gnt_raw : 2'b00;

  always_comb begin
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[GntD]) begin
      mem_wen   = bus.d_we;
      mem_addr  = bus.d_addr;
      mem_wdata = bus.d_wdata;
    end else if (gnt[GntIf]) begin
      mem_addr  = bus.if_addr;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    lat_cnt_d   = lat_cnt_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (gnt[GntD]) begin
          last_d = SrcD;
          // Writes complete in the grant cycle, so only reads leave idle.
          if (!bus.d_we) begin
            state_d   = StWaitD;
            lat_cnt_d = CntW'(MEM_LAT);
          end
        end else if (gnt[GntIf]) begin
          last_d    = SrcIf;
          state_d   = StWaitIf;
          lat_cnt_d = CntW'(MEM_LAT);
        end
      end
      StWaitIf, StWaitD: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (state_q == StWaitIf) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = bus.mem_rdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      state_q     <= StIdle;
      last_q      <= SrcIf;
      lat_cnt_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      lat_cnt_q   <= lat_cnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.if_gnt    = gnt[GntIf];
  assign bus.d_gnt     = gnt[GntD];
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_wen   = mem_wen;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LAT1 round-robin, LAT1 D-priority, LAT3
// round-robin), each with a latency-accurate memory model and a read scoreboard.
module tb_mem_arbiter;

  typedef struct {
    int          k;
    bit          is_d;
    logic [31:0] data;
    int          due;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  sb_t sb[$];

  logic [2:0]       rst_n = '0;
  logic [2:0]       if_req = '0, d_req = '0, d_we = '0;
  logic [2:0][31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [2:0]       if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wen;
  logic [2:0][31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  function automatic int lat_of(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic sb_check(input int k, input bit is_d, input logic [31:0] data);
    sb_t e;
    if (sb.size() == 0) begin
      check_eq($sformatf("rvalid_expected_%0d", k), 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check_eq("rv_dut", k, e.k);
    check_eq("rv_port", {31'b0, is_d}, {31'b0, e.is_d});
    check_eq("rv_data", data, e.data);
    check_eq("rv_cycle", cyc, e.due);
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned Lat  = (k == 2) ? 3 : 1;
    localparam int unsigned Prio = (k == 1) ? 1 : 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .MEM_LAT (Lat),
      .D_PRIO  (Prio)
    ) u_dut (
      .clk_i  (clk),
      .res_ni (rst_n[k]),
      .bus    (bus.slave)
    );

    assign bus.if_req  = if_req[k];
    assign bus.if_addr = if_addr[k];
    assign bus.d_req   = d_req[k];
    assign bus.d_we    = d_we[k];
    assign bus.d_addr  = d_addr[k];
    assign bus.d_wdata = d_wdata[k];
    assign if_gnt[k]    = bus.if_gnt;
    assign d_gnt[k]     = bus.d_gnt;
    assign if_rvalid[k] = bus.if_rvalid;
    assign d_rvalid[k]  = bus.d_rvalid;
    assign if_rdata[k]  = bus.if_rdata;
    assign d_rdata[k]   = bus.d_rdata;
    assign mem_wen[k]   = bus.mem_wen;
    assign mem_addr[k]  = bus.mem_addr;
    assign mem_wdata[k] = bus.mem_wdata;

    // Memory: captures the address at the grant edge, data appears Lat cycles later.
    logic [31:0] mem  [256];
    logic [31:0] pipe [Lat];
    initial begin
      for (int i = 0; i < 256; i++) mem[i] = {4{i[7:0]}};
      mem[8'h10] = 32'hDEADBEEF;
      for (int i = 0; i < int'(Lat); i++) pipe[i] = '0;
    end
    always @(posedge clk) begin
      if (bus.mem_wen) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      pipe[0] <= (bus.if_gnt || (bus.d_gnt && !bus.mem_wen)) ? mem[bus.mem_addr[7:0]] : 32'h0;
      for (int i = 1; i < int'(Lat); i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[Lat-1];

    always @(negedge clk) begin
      if (if_rvalid[k]) sb_check(k, 1'b0, if_rdata[k]);
      if (d_rvalid[k])  sb_check(k, 1'b1, d_rdata[k]);
    end
  end

  // Called just after a rising edge; returns just after the edge following the grant.
  task automatic issue(input int k, input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, output int gcyc);
    bit got = 1'b0;
    gcyc = -1;
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (is_d ? d_gnt[k] : if_gnt[k]) begin
        got  = 1'b1;
        gcyc = cyc;
        check_eq("mem_addr", mem_addr[k], addr);
        check_eq("mem_wen", {31'b0, mem_wen[k]}, {31'b0, we});
        check_eq("mem_wdata", mem_wdata[k], is_d ? wdata : 32'h0);
        if (!we) sb.push_back('{k: k, is_d: is_d, data: exp_rdata, due: cyc + lat_of(k) + 1});
      end
    end
    check_eq($sformatf("gnt_seen_%0d", k), {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    if (is_d) d_req[k] = 1'b0;
    else      if_req[k] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sb.size() > 0; n++) @(posedge clk);
    check_eq("drain", 32'(sb.size()), 32'd0);
    #1;
  endtask

  task automatic do_reset(input int k, input bit hold_reqs);
    rst_n[k] = 1'b0;
    if_req[k] = hold_reqs; d_req[k] = hold_reqs; d_we[k] = 1'b0;
    if_addr[k] = 32'h44; d_addr[k] = 32'h40; d_wdata[k] = 32'h0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      check_eq("rst_ctrl", {27'b0, if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], mem_wen[k]},
               32'h0);
      check_eq("rst_mem_addr", mem_addr[k], 32'h0);
      check_eq("rst_mem_wdata", mem_wdata[k], 32'h0);
      check_eq("rst_if_rdata", if_rdata[k], 32'h0);
      check_eq("rst_d_rdata", d_rdata[k], 32'h0);
    end
    @(posedge clk); #1;
    rst_n[k] = 1'b1;
  endtask

  // Both requesters read continuously; called in the cycle reset is released.
  task automatic contend(input int k, input bit dprio);
    bit exp_d, exp_i;
    if_req[k] = 1'b1; d_req[k] = 1'b1; d_we[k] = 1'b0;
    if_addr[k] = 32'h44; d_addr[k] = 32'h40;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_d = (i % 2 == 0) && (dprio || (i % 4 == 0));
      exp_i = (i % 2 == 0) && !dprio && (i % 4 == 2);
      check_eq($sformatf("ct%0d_d_gnt_%0d", k, i), {31'b0, d_gnt[k]}, {31'b0, exp_d});
      check_eq($sformatf("ct%0d_if_gnt_%0d", k, i), {31'b0, if_gnt[k]}, {31'b0, exp_i});
      if (d_gnt[k])  sb.push_back('{k: k, is_d: 1'b1, data: 32'h40404040, due: cyc + 2});
      if (if_gnt[k]) sb.push_back('{k: k, is_d: 1'b0, data: 32'h44444444, due: cyc + 2});
    end
    @(posedge clk); #1;
    if_req[k] = 1'b0; d_req[k] = 1'b0;
    drain();
  endtask

  initial begin
    int t0, t1;
    repeat (3) @(posedge clk);
    #1;

    // Reset with both requests active, then round-robin alternation starting with D.
    do_reset(0, 1'b1);
    contend(0, 1'b0);

    // IF read, LAT1; a D read is held meanwhile and must wait for the rvalid cycle.
    issue(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, t0);
    issue(0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h40404040, t1);
    check_eq("lat1_regrant", t1, t0 + 2);
    drain();

    // D write then read-back; the read is granted the very next cycle.
    issue(0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, t0);
    issue(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, t1);
    check_eq("wr_then_rd", t1, t0 + 1);
    drain();
    issue(0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h44444444, t0);
    drain();
    check_eq("d_rdata_hold", d_rdata[0], 32'hCAFEF00D);

    // Reset in the cycle after an IF read grant: the read is lost.
    issue(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, t0);
    void'(sb.pop_back());
    do_reset(0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check_eq($sformatf("no_rvalid_after_rst_%0d", n), {31'b0, if_rvalid[0]}, 32'h0);
    end
    @(posedge clk); #1;
    issue(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, t0);
    drain();

    // Fixed priority: D wins every tie while held.
    do_reset(1, 1'b1);
    contend(1, 1'b1);

    // LAT3: next grant only once rvalid is due at T+4.
    do_reset(2, 1'b0);
    issue(2, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, t0);
    issue(2, 1'b1, 1'b0, 32'h40, 32'h0, 32'h40404040, t1);
    check_eq("lat3_regrant", t1, t0 + 4);
    drain();

    repeat (4) @(posedge clk);
    check_eq("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
